// File: rtl/scr1_tb_imem_responder.sv
// Fixed-latency, in-order instruction-memory responder for SCR1 core-only benches.
// Define SCR1_TB_IMEM_RND_STALL_EN to add LFSR-driven random acceptance stalls.
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif

module scr1_tb_imem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned QDEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         core2imem_req,
    input  logic                         core2imem_cmd,
    input  logic [`SCR1_XLEN-1:0]        core2imem_addr,
    output logic                         imem2core_req_ack,
    output logic [31:0]                  imem2core_rdata,
    output logic [1:0]                   imem2core_resp,
    input  logic                         tb_wr_en,
    input  logic [$clog2(MEM_WORDS)-1:0] tb_wr_addr,
    input  logic [31:0]                  tb_wr_data,
    output logic [31:0]                  resp_ok_cnt,
    output logic [31:0]                  resp_err_cnt
);

    localparam int unsigned XLEN = `SCR1_XLEN;
    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam int unsigned PW   = $clog2(QDEPTH);

    localparam logic [XLEN-3:0] WORD_LIMIT = (XLEN-2)'(MEM_WORDS);
    localparam logic [PW:0]     FULL_CNT   = (PW+1)'(QDEPTH);
    // The acceptance cycle counts as age 0, so a stored entry lags that count by one.
    localparam logic [3:0]      POP_AGE    = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);
    localparam bit              BYPASS     = (LATENCY == 1);

    localparam logic [1:0] RESP_IDLE = 2'b00;
    localparam logic [1:0] RESP_OKAY = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    logic [31:0] mem [MEM_WORDS];

    logic [XLEN-1:0] q_addr_q [QDEPTH];
    logic [XLEN-1:0] q_addr_d [QDEPTH];
    logic            q_cmd_q  [QDEPTH];
    logic            q_cmd_d  [QDEPTH];
    logic [3:0]      q_age_q  [QDEPTH];
    logic [3:0]      q_age_d  [QDEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    logic [1:0]  resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ok_cnt_q, ok_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    logic            stall;
    logic            full;
    logic            empty;
    logic            accept;
    logic            push;
    logic            pop;
    logic            q_pop;
    logic            head_ready;
    logic [XLEN-1:0] pop_addr;
    logic            pop_cmd;
    logic [XLEN-3:0] pop_word;
    logic            pop_err;
    logic [31:0]     mem_rd;

`ifdef SCR1_TB_IMEM_RND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        stall  = lfsr_q[0] & lfsr_q[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // Preload port deliberately ignores reset: memory contents survive it.
    always_ff @(posedge clk) begin
        if (tb_wr_en) begin
            mem[tb_wr_addr] <= tb_wr_data;
        end
    end

    always_comb begin
        full              = (cnt_q == FULL_CNT);
        empty             = (cnt_q == '0);
        imem2core_req_ack = !rst && !full && !stall;
        accept            = core2imem_req && imem2core_req_ack;
        head_ready        = !empty && (q_age_q[rd_ptr_q] == POP_AGE);

        if (BYPASS) begin
            push     = 1'b0;
            pop      = accept;
            q_pop    = 1'b0;
            pop_addr = core2imem_addr;
            pop_cmd  = core2imem_cmd;
        end else begin
            push     = accept;
            pop      = head_ready;
            q_pop    = head_ready;
            pop_addr = q_addr_q[rd_ptr_q];
            pop_cmd  = q_cmd_q[rd_ptr_q];
        end

        pop_word = pop_addr[XLEN-1:2];
        pop_err  = pop_cmd || (pop_addr[1:0] != 2'b00) || (pop_word >= WORD_LIMIT);
        mem_rd   = mem[pop_word[AW-1:0]];
    end

    always_comb begin
        q_addr_d = q_addr_q;
        q_cmd_d  = q_cmd_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        for (int i = 0; i < int'(QDEPTH); i++) begin
            q_age_d[i] = (q_age_q[i] == 4'hF) ? 4'hF : q_age_q[i] + 4'd1;
        end

        if (push) begin
            q_addr_d[wr_ptr_q] = core2imem_addr;
            q_cmd_d[wr_ptr_q]  = core2imem_cmd;
            q_age_d[wr_ptr_q]  = 4'd0;
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end

        if (q_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !q_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && q_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        resp_d    = RESP_IDLE;
        rdata_d   = '0;
        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;

        if (pop) begin
            if (pop_err) begin
                resp_d    = RESP_ERR;
                err_cnt_d = err_cnt_q + 32'd1;
            end else begin
                resp_d   = RESP_OKAY;
                rdata_d  = mem_rd;
                ok_cnt_d = ok_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                q_addr_q[i] <= '0;
                q_cmd_q[i]  <= 1'b0;
                q_age_q[i]  <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            resp_q    <= RESP_IDLE;
            rdata_q   <= '0;
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            q_addr_q  <= q_addr_d;
            q_cmd_q   <= q_cmd_d;
            q_age_q   <= q_age_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign imem2core_resp  = resp_q;
    assign imem2core_rdata = rdata_q;
    assign resp_ok_cnt     = ok_cnt_q;
    assign resp_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_scr1_tb_imem_responder.sv
// Bench for scr1_tb_imem_responder: two instances (latency 2 and latency 15) checked
// against a response scoreboard that also verifies exact response timing.
module tb_scr1_tb_imem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 15;

    typedef struct packed {
        logic [31:0] due;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_req, a_cmd, a_ack;
    logic [31:0] a_addr, a_rdata, a_ok, a_err;
    logic [1:0]  a_resp;
    logic        b_req, b_cmd, b_ack;
    logic [31:0] b_addr, b_rdata, b_ok, b_err;
    logic [1:0]  b_resp;
    logic        tb_wr_en;
    logic [9:0]  tb_wr_addr;
    logic [31:0] tb_wr_data;

    logic [31:0] mem_model [1024];
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t e_a, e_b;

    int checks = 0;
    int errors = 0;

    scr1_tb_imem_responder #(.MEM_WORDS(1024), .LATENCY(LAT_A), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .core2imem_req(a_req), .core2imem_cmd(a_cmd), .core2imem_addr(a_addr),
        .imem2core_req_ack(a_ack), .imem2core_rdata(a_rdata), .imem2core_resp(a_resp),
        .tb_wr_en(tb_wr_en), .tb_wr_addr(tb_wr_addr), .tb_wr_data(tb_wr_data),
        .resp_ok_cnt(a_ok), .resp_err_cnt(a_err)
    );

    scr1_tb_imem_responder #(.MEM_WORDS(1024), .LATENCY(LAT_B), .QDEPTH(4)) dut15 (
        .clk(clk), .rst(rst),
        .core2imem_req(b_req), .core2imem_cmd(b_cmd), .core2imem_addr(b_addr),
        .imem2core_req_ack(b_ack), .imem2core_rdata(b_rdata), .imem2core_resp(b_resp),
        .tb_wr_en(tb_wr_en), .tb_wr_addr(tb_wr_addr), .tb_wr_data(tb_wr_data),
        .resp_ok_cnt(b_ok), .resp_err_cnt(b_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [31:0] addr, input logic cmd,
                                   input logic [31:0] due);
        exp_t e;
        e.due = due;
        if (cmd || (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd1024)) begin
            e.resp  = 2'b10;
            e.rdata = '0;
        end else begin
            e.resp  = 2'b01;
            e.rdata = mem_model[addr[11:2]];
        end
        return e;
    endfunction

    // Expected responses are pushed at acceptance and compared when the DUT responds.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_resp != 2'b00) begin
                if (sb_a.size() == 0) begin
                    check("a_unexpected_resp", 64'(a_resp), 64'd0);
                end else begin
                    e_a = sb_a.pop_front();
                    check("a_resp", 64'(a_resp), 64'(e_a.resp));
                    check("a_rdata", 64'(a_rdata), 64'(e_a.rdata));
                    check("a_latency", 64'(cyc), 64'(e_a.due));
                end
            end else begin
                check("a_idle_rdata", 64'(a_rdata), 64'd0);
            end
            if (a_req && a_ack) sb_a.push_back(model(a_addr, a_cmd, 32'(cyc + LAT_A)));

            if (b_resp != 2'b00) begin
                if (sb_b.size() == 0) begin
                    check("b_unexpected_resp", 64'(b_resp), 64'd0);
                end else begin
                    e_b = sb_b.pop_front();
                    check("b_resp", 64'(b_resp), 64'(e_b.resp));
                    check("b_rdata", 64'(b_rdata), 64'(e_b.rdata));
                    check("b_latency", 64'(cyc), 64'(e_b.due));
                end
            end
            if (b_req && b_ack) sb_b.push_back(model(b_addr, b_cmd, 32'(cyc + LAT_B)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        tb_wr_en   = 1'b1;
        tb_wr_addr = 10'(idx);
        tb_wr_data = data;
        tick();
        tb_wr_en = 1'b0;
        mem_model[idx] = data;
    endtask

    task automatic send_a(input logic [31:0] addr, input logic cmd);
        int n = 0;
        a_addr = addr;
        a_cmd  = cmd;
        a_req  = 1'b1;
        while (!a_ack && n < 100) begin
            tick();
            n++;
        end
        check("a_ack_wait", 64'(a_ack), 64'd1);
        tick();
        a_req = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] addr, input logic cmd);
        int n = 0;
        b_addr = addr;
        b_cmd  = cmd;
        b_req  = 1'b1;
        while (!b_ack && n < 100) begin
            tick();
            n++;
        end
        check("b_ack_wait", 64'(b_ack), 64'd1);
        tick();
        b_req = 1'b0;
    endtask

    initial begin
        int  ack_low;
        bit  got;
        rst = 1'b1;
        a_req = 1'b0; a_cmd = 1'b0; a_addr = '0;
        b_req = 1'b0; b_cmd = 1'b0; b_addr = '0;
        tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
        #1;
        check("ack_in_reset_a", 64'(a_ack), 64'd0);
        check("ack_in_reset_b", 64'(b_ack), 64'd0);

        for (int i = 0; i < 8; i++) begin
            preload(i, (i == 4) ? 32'h00C58533 : (32'hA5A5_0000 | 32'(i * 17 + 3)));
        end
        check("reset_resp", 64'(a_resp), 64'd0);
        check("reset_rdata", 64'(a_rdata), 64'd0);
        check("reset_ok_cnt", 64'(a_ok), 64'd0);
        check("reset_err_cnt", 64'(a_err), 64'd0);

        rst = 1'b0;
        #1;
        check("ack_after_reset_a", 64'(a_ack), 64'd1);
        check("ack_after_reset_b", 64'(b_ack), 64'd1);

        // Single fetch of word 4.
        send_a(32'h10, 1'b0);
        repeat (3) tick();
        check("single_drained", 64'(sb_a.size()), 64'd0);
        check("single_ok_cnt", 64'(a_ok), 64'd1);

        // Back-to-back fetches of 0x0..0x1C.
        for (int i = 0; i < 8; i++) send_a(32'(i * 4), 1'b0);
        repeat (4) tick();
        check("burst_drained", 64'(sb_a.size()), 64'd0);
        check("burst_ok_cnt", 64'(a_ok), 64'd9);

        // Misaligned, out-of-range, then write command.
        send_a(32'h2, 1'b0);
        send_a(32'd4096, 1'b0);
        repeat (3) tick();
        check("err_cnt_2", 64'(a_err), 64'd2);
        send_a(32'h0, 1'b1);
        repeat (3) tick();
        check("err_cnt_3", 64'(a_err), 64'd3);
        check("err_ok_unchanged", 64'(a_ok), 64'd9);

        // Preload landing on the pop edge returns the old word; the next fetch sees the new one.
        send_a(32'h4, 1'b0);
        tb_wr_en = 1'b1; tb_wr_addr = 10'd1; tb_wr_data = 32'hDEAD_BEEF;
        tick();
        tb_wr_en = 1'b0;
        mem_model[1] = 32'hDEAD_BEEF;
        repeat (2) tick();
        send_a(32'h4, 1'b0);
        repeat (3) tick();
        check("preload_race_drained", 64'(sb_a.size()), 64'd0);
        check("preload_race_ok_cnt", 64'(a_ok), 64'd11);

`ifndef SCR1_TB_IMEM_RND_STALL_EN
        // Queue-full behaviour on the latency-15 instance.
        b_addr = 32'h0; b_cmd = 1'b0; b_req = 1'b1;
        ack_low = 0;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            tick();
            if (b_resp != 2'b00) got = 1'b1;
            else if (!b_ack) ack_low++;
        end
        b_req = 1'b0;
        check("full_first_resp_seen", 64'(got), 64'd1);
        check("full_ack_after_pop", 64'(b_ack), 64'd1);
        check("full_ack_low_cycles", 64'(ack_low), 64'd11);
        repeat (20) tick();
        check("full_drained", 64'(sb_b.size()), 64'd0);
        check("full_ok_cnt", 64'(b_ok), 64'd4);
`else
        begin
            int acc = 0;
            int stalls = 0;
            int ncyc = 0;
            a_req = 1'b1;
            a_cmd = 1'b0;
            while (acc < 1000 && ncyc < 5000) begin
                a_addr = 32'((acc % 8) * 4);
                if (a_ack) acc++;
                else stalls++;
                ncyc++;
                tick();
            end
            a_req = 1'b0;
            repeat (4) tick();
            check("stall_all_accepted", 64'(acc), 64'd1000);
            check("stall_drained", 64'(sb_a.size()), 64'd0);
            check("stall_ratio_low", 64'(stalls * 100 >= ncyc * 20), 64'd1);
            check("stall_ratio_high", 64'(stalls * 100 <= ncyc * 30), 64'd1);
        end
`endif

        // Reset while a response is showing and three requests remain queued.
        for (int i = 0; i < 4; i++) send_b(32'h0, 1'b0);
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            tick();
            if (b_resp != 2'b00) got = 1'b1;
        end
        check("rst_resp_seen", 64'(got), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_resp_idle", 64'(b_resp), 64'd0);
        check("rst_rdata_zero", 64'(b_rdata), 64'd0);
        check("rst_ack_low", 64'(b_ack), 64'd0);
        sb_a.delete();
        sb_b.delete();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ok_cnt_cleared", 64'(b_ok), 64'd0);
        repeat (20) tick();
        send_b(32'h10, 1'b0);
        repeat (16) tick();
        check("post_rst_b_drained", 64'(sb_b.size()), 64'd0);
        check("post_rst_b_ok_cnt", 64'(b_ok), 64'd1);
        send_a(32'h10, 1'b0);
        repeat (3) tick();
        check("post_rst_a_drained", 64'(sb_a.size()), 64'd0);
        check("post_rst_a_ok_cnt", 64'(a_ok), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
